// File: rtl/video_pkg.sv
// Shared video timing defaults (720p60 CEA-861).
// Consumers import this to size buffers and counters.
package video_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;
  localparam int DEF_FPS      = 60;

  localparam int H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD counter with enable, look-ahead next value
// and a wrap pulse asserted on the enabled terminal count.
module wrap_counter #(
  parameter int MOD     = 2,
  parameter int W       = 1,
  parameter int RST_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_val,
  output logic [W-1:0] o_nxt,
  output logic         o_wrap
);

  logic [W-1:0] r_val;

  assign o_wrap = i_en && (r_val == W'(MOD - 1));
  assign o_val  = r_val;

  always_comb begin
    o_nxt = r_val;
    if (o_wrap)
      o_nxt = '0;
    else if (i_en)
      o_nxt = r_val + W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_val <= W'(RST_VAL);
    else
      r_val <= o_nxt;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, active
// flag, new-frame pulse and frame counter, all registered.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int FPS      = DEF_FPS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HSB = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VA  = 10'(V_ACTIVE);
  localparam logic [9:0]  VSB = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VSE = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic [5:0]  w_fc_nxt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_fc_wrap;
  logic        w_nf_nxt;
  logic        w_unused;

  logic r_hs;
  logic r_vs;
  logic r_ad;
  logic r_nf;

  wrap_counter #(
    .MOD(H_TOT), .W(11), .RST_VAL(H_TOT - 1)
  ) u_hcnt (
    .i_clk  (clk_in),
    .i_rst_n(rst_in),
    .i_en   (1'b1),
    .o_val  (hcount_out),
    .o_nxt  (w_h_nxt),
    .o_wrap (w_h_wrap)
  );

  wrap_counter #(
    .MOD(V_TOT), .W(10), .RST_VAL(V_TOT - 1)
  ) u_vcnt (
    .i_clk  (clk_in),
    .i_rst_n(rst_in),
    .i_en   (w_h_wrap),
    .o_val  (vcount_out),
    .o_nxt  (w_v_nxt),
    .o_wrap (w_v_wrap)
  );

  // Flags are decoded from next-state counts so they land
  // on the same edge as the position they describe.
  assign w_nf_nxt = (w_h_nxt == HA) && (w_v_nxt == VA);

  wrap_counter #(
    .MOD(FPS), .W(6), .RST_VAL(0)
  ) u_fcnt (
    .i_clk  (clk_in),
    .i_rst_n(rst_in),
    .i_en   (w_nf_nxt),
    .o_val  (fc_out),
    .o_nxt  (w_fc_nxt),
    .o_wrap (w_fc_wrap)
  );

  assign w_unused = &{1'b0, w_v_wrap, w_fc_wrap, w_fc_nxt};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_ad <= 1'b0;
      r_nf <= 1'b0;
    end else begin
      r_hs <= (w_h_nxt >= HSB) && (w_h_nxt < HSE);
      r_vs <= (w_v_nxt >= VSB) && (w_v_nxt < VSE);
      r_ad <= (w_h_nxt < HA) && (w_v_nxt < VA);
      r_nf <= w_nf_nxt;
    end
  end

  assign hs_out = r_hs;
  assign vs_out = r_vs;
  assign ad_out = r_ad;
  assign nf_out = r_nf;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default-timing instance for line checks,
// small-timing instance for frame, fc wrap and mid reset.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;

  logic [10:0] d_h;
  logic [9:0]  d_v;
  logic        d_hs, d_vs, d_ad, d_nf;
  logic [5:0]  d_fc;

  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic        s_hs, s_vs, s_ad, s_nf;
  logic [5:0]  s_fc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_timing_gen u_dut_d (
    .clk_in    (clk),
    .rst_in    (rst_d),
    .hcount_out(d_h),
    .vcount_out(d_v),
    .hs_out    (d_hs),
    .vs_out    (d_vs),
    .ad_out    (d_ad),
    .nf_out    (d_nf),
    .fc_out    (d_fc)
  );

  // 28 x 17 raster: hs 20..22, vs 12..13, nf at (16,10)
  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .FPS(60)
  ) u_dut_s (
    .clk_in    (clk),
    .rst_in    (rst_s),
    .hcount_out(s_h),
    .vcount_out(s_v),
    .hs_out    (s_hs),
    .vs_out    (s_vs),
    .ad_out    (s_ad),
    .nf_out    (s_nf),
    .fc_out    (s_fc)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_n, hs_first, hs_last, vs_bad;
    int eh, ev, bad, nf_k, t, nf_t0, nf_t1, pfc;
    int bud;
    logic done;

    repeat (5) step();
    chk("rst_d_h", d_h, 1649);
    chk("rst_d_v", d_v, 749);
    chk("rst_d_flags", {d_hs, d_vs, d_ad, d_nf}, 0);
    chk("rst_d_fc", d_fc, 0);
    chk("rst_s_h", s_h, 27);
    chk("rst_s_v", s_v, 16);

    rst_d = 1'b1;
    rst_s = 1'b1;
    step();
    chk("rel_d_h", d_h, 0);
    chk("rel_d_v", d_v, 0);
    chk("rel_d_ad", d_ad, 1);
    chk("rel_d_hs_vs", {d_hs, d_vs}, 0);
    chk("rel_d_fc", d_fc, 0);
    chk("rel_s_hv", {21'(s_h), 11'(s_v)}, 0);
    rst_s = 1'b0;

    repeat (3 * 1650 + 1649) step();
    chk("d_h_1649", d_h, 1649);
    chk("d_v_3", d_v, 3);
    step();
    chk("d_wrap_h", d_h, 0);
    chk("d_wrap_v", d_v, 4);
    repeat (1279) step();
    chk("d_h_1279", d_h, 1279);
    chk("d_ad_1279", d_ad, 1);
    step();
    chk("d_ad_1280", d_ad, 0);

    hs_n = 0; hs_first = -1; hs_last = -1; vs_bad = 0;
    for (int i = 0; i < 1650; i++) begin
      step();
      if (d_hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = d_h;
        hs_last = d_h;
      end
      if (d_vs) vs_bad++;
    end
    chk("d_hs_width", hs_n, 40);
    chk("d_hs_first", hs_first, 1390);
    chk("d_hs_last", hs_last, 1429);
    chk("d_vs_low", vs_bad, 0);

    step();
    rst_s = 1'b1;
    step();
    eh = 0; ev = 0; bad = 0; nf_k = 0;
    nf_t0 = -1; nf_t1 = -1; pfc = 0;
    for (t = 0; t < 800; t++) begin
      if (s_h != eh || s_v != ev) bad++;
      if (s_ad != (eh < 16 && ev < 10)) bad++;
      if (s_hs != (eh >= 20 && eh < 23)) bad++;
      if (s_vs != (ev >= 12 && ev < 14)) bad++;
      if (s_nf != (eh == 16 && ev == 10)) bad++;
      if (s_nf) begin
        if (nf_k == 0) begin
          nf_t0 = t;
          chk("s_fc_before_nf", pfc, 0);
          chk("s_fc_at_nf1", s_fc, 1);
        end else if (nf_k == 1) begin
          nf_t1 = t;
          chk("s_fc_at_nf2", s_fc, 2);
        end
        nf_k++;
      end
      pfc = s_fc;
      step();
      eh++;
      if (eh == 28) begin
        eh = 0;
        ev = (ev == 16) ? 0 : ev + 1;
      end
    end
    chk("s_frame_model", bad, 0);
    chk("s_nf_t0", nf_t0, 296);
    chk("s_nf_period", nf_t1 - nf_t0, 476);
    chk("s_fc_after2", s_fc, 2);

    done = 1'b0;
    pfc = s_fc;
    for (bud = 0; bud < 61 * 476 && !done; bud++) begin
      step();
      if (s_nf) begin
        nf_k++;
        if (nf_k == 60) begin
          chk("s_fc_prev59", pfc, 59);
          chk("s_fc_wrap0", s_fc, 0);
          done = 1'b1;
        end
      end
      pfc = s_fc;
    end
    chk("s_60_frames_seen", done, 1);

    done = 1'b0;
    for (bud = 0; bud < 600 && !done; bud++) begin
      if (s_h == 9 && s_v == 5) done = 1'b1;
      else step();
    end
    chk("s_reach_9_5", done, 1);
    rst_s = 1'b0;
    step();
    chk("mid_rst_h", s_h, 27);
    chk("mid_rst_v", s_v, 16);
    chk("mid_rst_flags", {s_hs, s_vs, s_ad, s_nf}, 0);
    chk("mid_rst_fc", s_fc, 0);
    rst_s = 1'b1;
    step();
    chk("mid_rel_h", s_h, 0);
    chk("mid_rel_v", s_v, 0);
    chk("mid_rel_fc", s_fc, 0);
    chk("mid_rel_ad", s_ad, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 40, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 220, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 5, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 5, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 20, vertical back porch in lines.
REQ-009 SHALL have parameter FPS, default 60, frame-counter modulus.
REQ-010 clk_in  input  1  pixel clock; one clock domain; all state changes on its rising edge.
REQ-011 rst_in  input  1  synchronous, active-low reset.
REQ-012 hcount_out  output  11  current horizontal position, [0, H_TOTAL).
REQ-013 vcount_out  output  10  current vertical position, [0, V_TOTAL).
REQ-014 hs_out  output  1  horizontal sync, active high.
REQ-015 vs_out  output  1  vertical sync, active high.
REQ-016 ad_out  output  1  active-draw flag.
REQ-017 nf_out  output  1  single-cycle new-frame pulse.
REQ-018 fc_out  output  6  frame count modulo FPS.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
REQ-020 SHALL advance hcount_out by 1 every cycle out of reset; at H_TOTAL-1 SHALL wrap to 0.
REQ-021 SHALL advance vcount_out by 1 only on the hcount wrap edge; at V_TOTAL-1 together with an hcount wrap SHALL go to 0.
REQ-022 All outputs SHALL be registered and SHALL describe the same (hcount_out, vcount_out) position in the same cycle; no combinational output paths.
REQ-023 ad_out SHALL be 1 iff hcount_out < H_ACTIVE and vcount_out < V_ACTIVE.
REQ-024 hs_out SHALL be 1 iff H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (1390..1429).
REQ-025 vs_out SHALL be 1 iff V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (725..729), for whole lines irrespective of hcount_out.
REQ-026 nf_out SHALL be 1 for exactly the one cycle where hcount_out == H_ACTIVE and vcount_out == V_ACTIVE.
REQ-027 fc_out SHALL increment in the same cycle nf_out is 1, wrapping FPS-1 -> 0.
REQ-028 Consecutive nf_out pulses SHALL be exactly H_TOTAL*V_TOTAL (1,237,500) cycles apart.
REQ-029 Counter arithmetic SHALL compare against next-state values so no flag lags its position by a cycle; H_TOTAL <= 2048 and V_TOTAL <= 1024 are legality limits.

Reset
REQ-030 On a rising edge with rst_in == 0: hcount_out = H_TOTAL-1, vcount_out = V_TOTAL-1, hs_out = 0, vs_out = 0, ad_out = 0, nf_out = 0, fc_out = 0.
REQ-031 First rising edge with rst_in == 1 SHALL produce hcount_out = 0, vcount_out = 0, ad_out = 1.
REQ-032 Reset asserted mid-frame SHALL override counting on that edge; no partial frame counts toward fc_out.

Structure
REQ-033 Timing defaults (1280/110/40/220, 720/5/5/20) and H_TOTAL/V_TOTAL SHALL live in shared package video_pkg, also used by video consumers.
REQ-034 One sub-module, wrap_counter (parameterised modulus, enable in, value out, wrap pulse out), SHALL be instantiated for horizontal, vertical and frame counters.

Verification
REQ-035 Hold rst_in low 5 cycles, release -> first edge shows h=0, v=0, ad=1, hs=0, vs=0, fc=0.
REQ-036 Run to h=1649, v=3 -> next cycle h=0, v=4; at h=1279 ad=1, at h=1280 ad=0.
REQ-037 Scan one line -> hs_out high exactly 40 cycles, first at h=1390, last at h=1429.
REQ-038 Run to (1280,720) -> nf_out=1 for one cycle, fc 0->1; vs_out high on lines 725..729 only; next nf after 1,237,500 cycles.
REQ-039 Run 60 frames -> fc_out wraps 59->0 on the 60th nf pulse.
REQ-040 Assert rst_in at h=500, v=300 for 1 cycle -> outputs equal REQ-030 values; one edge after release h=0, v=0, fc=0.
